// File: rtl/alpha_calc_scheduler_if.sv
// Valid/ready stream carrying one data word; the producer side uses master.
interface alpha_calc_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/alpha_calc_scheduler.sv
// Joins mean and sample streams into blocks for alpha_calc, credit-limited by alpha returns.
// Upstream handshake to calc valid is 1 cycle; upstream stalls while a pair register cannot drain.
module alpha_calc_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int MAX_INFLIGHT   = 2,
    parameter int COUNT_WIDTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    alpha_calc_scheduler_if.slave         x,
    alpha_calc_scheduler_if.slave         xhat,
    alpha_calc_scheduler_if.slave         xmean,
    alpha_calc_scheduler_if.slave         xhatmean,
    alpha_calc_scheduler_if.master        calc_x,
    alpha_calc_scheduler_if.master        calc_xhat,
    alpha_calc_scheduler_if.master        calc_xmean,
    alpha_calc_scheduler_if.master        calc_xhatmean,
    input  logic                          alpha_valid,
    input  logic                          alpha_ready,
    output logic                          busy,
    output logic [3:0]                    inflight,
    output logic [COUNT_WIDTH-1:0]        blocks_done
);
    typedef enum logic {S_MEAN = 1'b0, S_SAMPLES = 1'b1} state_t;

    localparam logic [BLOCK_SIZE_LOG-1:0] CNT_LAST    = '1;
    localparam logic [3:0]                MAX_CREDITS = 4'(MAX_INFLIGHT);

    state_t                  state_q, state_d;
    logic [BLOCK_SIZE_LOG-1:0] cnt_q, cnt_d;
    logic [3:0]              inflight_q, inflight_d;
    logic [COUNT_WIDTH-1:0]  blocks_done_q, blocks_done_d;
    logic                    xm_pend_q, xm_pend_d, hm_pend_q, hm_pend_d;
    logic                    x_pend_q, x_pend_d, xh_pend_q, xh_pend_d;
    logic [DATA_WIDTH-1:0]   xm_dat_q, xm_dat_d, hm_dat_q, hm_dat_d;
    logic [DATA_WIDTH-1:0]   x_dat_q, x_dat_d, xh_dat_q, xh_dat_d;
    logic                    mean_free, samp_free, mean_load, samp_load, alpha_ret;

    always_comb begin
        // A pair register can reload in the same cycle its last pending word drains.
        mean_free = (!xm_pend_q || calc_xmean.ready) && (!hm_pend_q || calc_xhatmean.ready);
        samp_free = (!x_pend_q || calc_x.ready) && (!xh_pend_q || calc_xhat.ready);
        mean_load = rst && (state_q == S_MEAN) && mean_free && enable &&
                    (inflight_q < MAX_CREDITS) && xmean.valid && xhatmean.valid;
        samp_load = rst && (state_q == S_SAMPLES) && samp_free && x.valid && xhat.valid;
        alpha_ret = alpha_valid && alpha_ready;

        xm_pend_d = mean_load || (xm_pend_q && !calc_xmean.ready);
        hm_pend_d = mean_load || (hm_pend_q && !calc_xhatmean.ready);
        x_pend_d  = samp_load || (x_pend_q && !calc_x.ready);
        xh_pend_d = samp_load || (xh_pend_q && !calc_xhat.ready);
        xm_dat_d  = mean_load ? xmean.data    : xm_dat_q;
        hm_dat_d  = mean_load ? xhatmean.data : hm_dat_q;
        x_dat_d   = samp_load ? x.data        : x_dat_q;
        xh_dat_d  = samp_load ? xhat.data     : xh_dat_q;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (mean_load) begin
            state_d = S_SAMPLES;
            cnt_d   = '0;
        end
        if (samp_load) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = S_MEAN;
        end

        // Returns with no block outstanding are dropped so the credit count cannot underflow.
        inflight_d = inflight_q;
        if (mean_load && !(alpha_ret && inflight_q != 4'd0))
            inflight_d = inflight_q + 4'd1;
        else if (!mean_load && alpha_ret && inflight_q != 4'd0)
            inflight_d = inflight_q - 4'd1;
        blocks_done_d = blocks_done_q + COUNT_WIDTH'(alpha_ret);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_MEAN;
            cnt_q         <= '0;
            inflight_q    <= '0;
            blocks_done_q <= '0;
            xm_pend_q     <= 1'b0;
            hm_pend_q     <= 1'b0;
            x_pend_q      <= 1'b0;
            xh_pend_q     <= 1'b0;
            xm_dat_q      <= '0;
            hm_dat_q      <= '0;
            x_dat_q       <= '0;
            xh_dat_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            inflight_q    <= inflight_d;
            blocks_done_q <= blocks_done_d;
            xm_pend_q     <= xm_pend_d;
            hm_pend_q     <= hm_pend_d;
            x_pend_q      <= x_pend_d;
            xh_pend_q     <= xh_pend_d;
            xm_dat_q      <= xm_dat_d;
            hm_dat_q      <= hm_dat_d;
            x_dat_q       <= x_dat_d;
            xh_dat_q      <= xh_dat_d;
        end
    end

    assign xmean.ready         = mean_load;
    assign xhatmean.ready      = mean_load;
    assign x.ready             = samp_load;
    assign xhat.ready          = samp_load;
    assign calc_xmean.valid    = xm_pend_q;
    assign calc_xmean.data     = xm_dat_q;
    assign calc_xhatmean.valid = hm_pend_q;
    assign calc_xhatmean.data  = hm_dat_q;
    assign calc_x.valid        = x_pend_q;
    assign calc_x.data         = x_dat_q;
    assign calc_xhat.valid     = xh_pend_q;
    assign calc_xhat.data      = xh_dat_q;
    assign busy        = (state_q == S_SAMPLES) || xm_pend_q || hm_pend_q || x_pend_q || xh_pend_q;
    assign inflight    = inflight_q;
    assign blocks_done = blocks_done_q;
endmodule

// File: tb/tb_alpha_calc_scheduler.sv
// Directed bench for alpha_calc_scheduler with a queue-based block model checked every cycle.
module tb_alpha_calc_scheduler;
    localparam int DW = 16, BSL = 2, NS = 4, MAXI = 2, CW = 16;

    logic clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic alpha_valid = 1'b0, alpha_ready = 1'b0;
    logic busy;
    logic [3:0] inflight;
    logic [CW-1:0] blocks_done;

    alpha_calc_scheduler_if #(.DATA_WIDTH(DW)) x_if(), xh_if(), xm_if(), hm_if();
    alpha_calc_scheduler_if #(.DATA_WIDTH(DW)) cx_if(), cxh_if(), cxm_if(), chm_if();

    alpha_calc_scheduler #(.DATA_WIDTH(DW), .BLOCK_SIZE_LOG(BSL), .MAX_INFLIGHT(MAXI),
                           .COUNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .x(x_if), .xhat(xh_if), .xmean(xm_if), .xhatmean(hm_if),
        .calc_x(cx_if), .calc_xhat(cxh_if), .calc_xmean(cxm_if), .calc_xhatmean(chm_if),
        .alpha_valid(alpha_valid), .alpha_ready(alpha_ready),
        .busy(busy), .inflight(inflight), .blocks_done(blocks_done));

    always #5 clk = ~clk;

    int vectors = 0, errors = 0, cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Upstream sources: words wait in queues and are presented in order.
    int unsigned src_x[$], src_xh[$], src_m[$], src_hm[$];
    bit gate_xh = 1'b1;
    bit hs_x, hs_xh, hs_m, hs_hm;

    initial begin
        x_if.valid = 0; x_if.data = '0; xh_if.valid = 0; xh_if.data = '0;
        xm_if.valid = 0; xm_if.data = '0; hm_if.valid = 0; hm_if.data = '0;
        forever begin
            @(posedge clk); #1;
            if (hs_x  && src_x.size()  > 0) void'(src_x.pop_front());
            if (hs_xh && src_xh.size() > 0) void'(src_xh.pop_front());
            if (hs_m  && src_m.size()  > 0) void'(src_m.pop_front());
            if (hs_hm && src_hm.size() > 0) void'(src_hm.pop_front());
            x_if.valid  = src_x.size() > 0;
            x_if.data   = src_x.size() > 0 ? DW'(src_x[0]) : '0;
            xh_if.valid = gate_xh && src_xh.size() > 0;
            xh_if.data  = src_xh.size() > 0 ? DW'(src_xh[0]) : '0;
            xm_if.valid = src_m.size() > 0;
            xm_if.data  = src_m.size() > 0 ? DW'(src_m[0]) : '0;
            hm_if.valid = src_hm.size() > 0;
            hm_if.data  = src_hm.size() > 0 ? DW'(src_hm[0]) : '0;
        end
    end

    // Model: words waiting at each calc port, block phase, credits and return count.
    logic [DW-1:0] q_cx[$], q_cxh[$], q_cxm[$], q_chm[$];
    bit m_in_mean = 1'b1;
    int m_cnt = 0, m_inflight = 0, m_done = 0;
    bit exp_mrdy, exp_srdy;

    // Observation logs for hand-computed expectations.
    int cx_cyc[$], cxm_cyc[$], mhs_cyc[$], alpha_cyc[$];
    logic [DW-1:0] cx_dat[$];
    int samp_hs = 0, n_cx = 0, n_cxh = 0, max_lead = 0;

    task automatic clear_logs();
        cx_cyc.delete(); cxm_cyc.delete(); mhs_cyc.delete(); alpha_cyc.delete(); cx_dat.delete();
        samp_hs = 0; n_cx = 0; n_cxh = 0; max_lead = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            q_cx.delete(); q_cxh.delete(); q_cxm.delete(); q_chm.delete();
            m_in_mean = 1'b1; m_cnt = 0; m_inflight = 0; m_done = 0;
        end
        chk("calc_x_valid",        cx_if.valid,  q_cx.size()  > 0);
        chk("calc_xhat_valid",     cxh_if.valid, q_cxh.size() > 0);
        chk("calc_xmean_valid",    cxm_if.valid, q_cxm.size() > 0);
        chk("calc_xhatmean_valid", chm_if.valid, q_chm.size() > 0);
        if (q_cx.size()  > 0) chk("calc_x_data",        cx_if.data,  q_cx[0]);
        if (q_cxh.size() > 0) chk("calc_xhat_data",     cxh_if.data, q_cxh[0]);
        if (q_cxm.size() > 0) chk("calc_xmean_data",    cxm_if.data, q_cxm[0]);
        if (q_chm.size() > 0) chk("calc_xhatmean_data", chm_if.data, q_chm[0]);
        exp_mrdy = rst && m_in_mean && enable && (m_inflight < MAXI) && xm_if.valid && hm_if.valid
                   && (q_cxm.size() == 0 || cxm_if.ready) && (q_chm.size() == 0 || chm_if.ready);
        exp_srdy = rst && !m_in_mean && x_if.valid && xh_if.valid
                   && (q_cx.size() == 0 || cx_if.ready) && (q_cxh.size() == 0 || cxh_if.ready);
        chk("xmean_ready",    xm_if.ready, exp_mrdy);
        chk("xhatmean_ready", hm_if.ready, exp_mrdy);
        chk("x_ready",        x_if.ready,  exp_srdy);
        chk("xhat_ready",     xh_if.ready, exp_srdy);
        chk("inflight",    inflight, m_inflight);
        chk("blocks_done", blocks_done, CW'(m_done));
        chk("busy", busy, !m_in_mean || q_cx.size() > 0 || q_cxh.size() > 0 ||
                          q_cxm.size() > 0 || q_chm.size() > 0);

        hs_x  = x_if.valid  && x_if.ready;
        hs_xh = xh_if.valid && xh_if.ready;
        hs_m  = xm_if.valid && xm_if.ready;
        hs_hm = hm_if.valid && hm_if.ready;
        if (cx_if.valid && cx_if.ready) begin cx_cyc.push_back(cyc); cx_dat.push_back(cx_if.data); n_cx++; end
        if (cxh_if.valid && cxh_if.ready) n_cxh++;
        if (n_cx - n_cxh > max_lead) max_lead = n_cx - n_cxh;
        if (cxm_if.valid && cxm_if.ready) cxm_cyc.push_back(cyc);
        if (hs_m) mhs_cyc.push_back(cyc);
        if (hs_x) samp_hs++;
        if (alpha_valid && alpha_ready) alpha_cyc.push_back(cyc);

        if (rst) begin
            if (q_cx.size()  > 0 && cx_if.ready)  void'(q_cx.pop_front());
            if (q_cxh.size() > 0 && cxh_if.ready) void'(q_cxh.pop_front());
            if (q_cxm.size() > 0 && cxm_if.ready) void'(q_cxm.pop_front());
            if (q_chm.size() > 0 && chm_if.ready) void'(q_chm.pop_front());
            if (exp_mrdy) begin
                q_cxm.push_back(xm_if.data); q_chm.push_back(hm_if.data);
                m_in_mean = 1'b0; m_cnt = 0;
            end
            if (exp_srdy) begin
                q_cx.push_back(x_if.data); q_cxh.push_back(xh_if.data);
                m_cnt++;
                if (m_cnt == NS) begin m_cnt = 0; m_in_mean = 1'b1; end
            end
            if (alpha_valid && alpha_ready) begin
                m_done++;
                m_inflight = m_inflight + int'(exp_mrdy) - int'(m_inflight > 0);
            end else begin
                m_inflight = m_inflight + int'(exp_mrdy);
            end
        end
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_block(input int m, input int hm, input int xb, input int xs, input int hb);
        src_m.push_back(m); src_hm.push_back(hm);
        for (int i = 0; i < NS; i++) begin
            src_x.push_back(xb + i); src_xh.push_back(hb + 2 * i * xs);
        end
    endtask

    task automatic pulse_alpha();
        alpha_valid = 1'b1; alpha_ready = 1'b1;
        tick(1);
        alpha_valid = 1'b0; alpha_ready = 1'b0;
    endtask

    initial begin
        cx_if.ready = 1; cxh_if.ready = 1; cxm_if.ready = 1; chm_if.ready = 1;
        #1;
        chk("reset calc_x_valid", cx_if.valid, 0);
        chk("reset inflight", inflight, 0);
        chk("reset blocks_done", blocks_done, 0);
        chk("reset busy", busy, 0);
        tick(3);
        rst = 1'b1; enable = 1'b1;

        // Single block: mean at +1, samples at +2..+5.
        clear_logs();
        push_block(640, 384, 512, 1, 256);
        tick(10);
        chk("t1 mean hs count", mhs_cyc.size(), 1);
        if (mhs_cyc.size() > 0 && cxm_cyc.size() > 0)
            chk("t1 xmean latency", cxm_cyc[0] - mhs_cyc[0], 1);
        chk("t1 sample transfers", cx_cyc.size(), 4);
        for (int i = 0; i < 4; i++) if (i < cx_cyc.size() && mhs_cyc.size() > 0) begin
            chk("t1 x cycle", cx_cyc[i] - mhs_cyc[0], 2 + i);
            chk("t1 x data", cx_dat[i], 512 + i);
        end
        chk("t1 inflight", inflight, 1);
        chk("t1 busy", busy, 0);

        // Credit limit: block 2 runs, block 3 held until one alpha returns.
        push_block(641, 385, 600, 1, 300);
        push_block(642, 386, 604, 1, 308);
        tick(20);
        chk("t2 total x transfers", cx_cyc.size(), 8);
        chk("t2 held means", src_m.size(), 1);
        chk("t2 held samples", src_x.size(), 4);
        chk("t2 inflight", inflight, 2);
        pulse_alpha();
        tick(12);
        chk("t2 alpha count", alpha_cyc.size(), 1);
        if (alpha_cyc.size() > 0 && mhs_cyc.size() > 2)
            chk("t2 restart delay", mhs_cyc[2] - alpha_cyc[0], 1);
        chk("t2 inflight after", inflight, 2);
        chk("t2 blocks_done", blocks_done, 1);
        chk("t2 total x transfers after", cx_cyc.size(), 12);

        // Alpha return coincident with a mean load.
        pulse_alpha();
        enable = 1'b0;
        clear_logs();
        push_block(700, 701, 520, 1, 320);
        tick(3);
        chk("t5 mean held while disabled", src_m.size(), 1);
        enable = 1'b1; alpha_valid = 1'b1; alpha_ready = 1'b1;
        tick(1);
        alpha_valid = 1'b0; alpha_ready = 1'b0;
        tick(8);
        if (mhs_cyc.size() > 0 && alpha_cyc.size() > 0)
            chk("t5 coincident", mhs_cyc[0], alpha_cyc[0]);
        chk("t5 inflight", inflight, 1);
        chk("t5 blocks_done", blocks_done, 3);

        // calc_xhat_ready toggling while calc_x_ready stays high.
        clear_logs();
        push_block(710, 711, 512, 1, 256);
        for (int i = 0; i < 14; i++) begin
            cxh_if.ready = i[0];
            tick(1);
        end
        cxh_if.ready = 1'b1;
        tick(4);
        chk("t3 max x lead", max_lead, 1);
        chk("t3 x transfers", cx_dat.size(), 4);
        for (int i = 0; i < 4; i++) if (i < cx_dat.size()) chk("t3 x order", cx_dat[i], 512 + i);

        // xhat_valid low with x_valid high.
        pulse_alpha();
        pulse_alpha();
        chk("t4 inflight drained", inflight, 0);
        clear_logs();
        src_m.push_back(720); src_hm.push_back(721);
        tick(3);
        gate_xh = 1'b0;
        for (int i = 0; i < NS; i++) begin src_x.push_back(530 + i); src_xh.push_back(330 + i); end
        tick(1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t4 x_valid offered", x_if.valid, 1);
            chk("t4 x_ready held", x_if.ready, 0);
            chk("t4 calc_x_valid idle", cx_if.valid, 0);
        end
        tick(1);
        gate_xh = 1'b1;
        tick(10);
        chk("t4 samples", samp_hs, 4);

        // Asynchronous reset mid-block.
        clear_logs();
        push_block(740, 741, 540, 1, 340);
        begin
            int n;
            n = 0;
            while (samp_hs < 2 && n < 20) begin @(negedge clk); n++; end
            chk("t6 reached counter 2", samp_hs, 2);
        end
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        chk("t6 calc_x_valid", cx_if.valid, 0);
        chk("t6 calc_xhat_valid", cxh_if.valid, 0);
        chk("t6 calc_xmean_valid", cxm_if.valid, 0);
        chk("t6 x_ready", x_if.ready, 0);
        chk("t6 xmean_ready", xm_if.ready, 0);
        chk("t6 inflight", inflight, 0);
        chk("t6 blocks_done", blocks_done, 0);
        tick(2);
        src_x.delete(); src_xh.delete(); src_m.delete(); src_hm.delete();
        tick(2);
        rst = 1'b1;
        clear_logs();
        for (int i = 0; i < NS + 1; i++) begin src_x.push_back(550 + i); src_xh.push_back(350 + i); end
        tick(3);
        chk("t6 no samples before mean", samp_hs, 0);
        src_m.push_back(750); src_hm.push_back(751);
        tick(10);
        chk("t6 samples after mean", samp_hs, 4);
        chk("t6 extra sample held", src_x.size(), 1);
        if (cxm_cyc.size() > 0 && cx_cyc.size() > 0) chk("t6 mean first", cxm_cyc[0] < cx_cyc[0], 1);
        for (int i = 0; i < 4; i++) if (i < cx_dat.size()) chk("t6 x data", cx_dat[i], 550 + i);
        chk("t6 inflight", inflight, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule

// File: doc/alpha_calc_scheduler.md
Name: alpha_calc_scheduler

Overview:
Sequences block-wise operation of alpha_calc. Joins the x/xhat sample streams and the xmean/xhatmean mean streams from upstream. Releases exactly one mean pair followed by 2^BLOCK_SIZE_LOG sample pairs per block. Limits the number of blocks in flight using a credit counter that is returned by alpha handshakes observed on alpha_calc's output.

Parameters:
DATA_WIDTH, 16, width of all x/xhat/mean data words
BLOCK_SIZE_LOG, 8, log2 of samples per block
MAX_INFLIGHT, 2, maximum blocks started whose alpha has not yet been transferred (1..15)
COUNT_WIDTH, 16, width of completed-block counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
enable  in  1  high: start new blocks; low: finish current block, then hold
x_valid/x_ready/x_data  in/out/in  1/1/DATA_WIDTH  upstream sample stream
xhat_valid/xhat_ready/xhat_data  in/out/in  1/1/DATA_WIDTH  upstream prediction stream
xmean_valid/xmean_ready/xmean_data  in/out/in  1/1/DATA_WIDTH  upstream block mean
xhatmean_valid/xhatmean_ready/xhatmean_data  in/out/in  1/1/DATA_WIDTH  upstream prediction mean
calc_x_valid/calc_x_ready/calc_x_data  out/in/out  1/1/DATA_WIDTH  to alpha_calc x
calc_xhat_valid/calc_xhat_ready/calc_xhat_data  out/in/out  1/1/DATA_WIDTH  to alpha_calc xhat
calc_xmean_valid/calc_xmean_ready/calc_xmean_data  out/in/out  1/1/DATA_WIDTH  to alpha_calc xmean
calc_xhatmean_valid/calc_xhatmean_ready/calc_xhatmean_data  out/in/out  1/1/DATA_WIDTH  to alpha_calc xhatmean
alpha_valid  in  1  monitored alpha_calc output valid
alpha_ready  in  1  monitored alpha consumer ready
busy  out  1  high when state is S_SAMPLES or any pending flag is set
inflight  out  4  blocks currently in flight
blocks_done  out  COUNT_WIDTH  alpha handshakes since reset, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (rst=0, async): state S_MEAN; all pending flags 0; all calc_*_valid 0; sample counter 0; inflight 0; blocks_done 0; all upstream ready 0. Reset mid-block discards held data; no partial block resumes.
- Pair registers: one for the mean pair, one for the sample pair. Each holds two data words plus two pending flags (one per downstream channel).
  - calc_*_valid equals its pending flag. A flag clears on its channel's valid&ready. The two channels drain independently.
  - calc valids never depend on calc readies.
- Mean pair register "free" = both flags clear, or the remaining set flags clear this cycle. Same rule for the sample pair register.
- S_MEAN:
  - xmean_ready = xhatmean_ready = free_mean & enable & (inflight < MAX_INFLIGHT) & both mean valids.
  - Upstream ready asserts only when both means are valid (join); xmean/xhatmean handshake in the same cycle.
  - On load: both mean flags set, inflight increments, go to S_SAMPLES, counter = 0.
- S_SAMPLES:
  - x_ready = xhat_ready = free_sample & x_valid & xhat_valid.
  - On load: both sample flags set, counter increments.
  - On the load with counter = 2^BLOCK_SIZE_LOG-1: counter resets to 0, go to S_MEAN.
  - Mean flags need not be clear before samples flow.
- Latency: 1 cycle from upstream handshake to calc valid. Throughput: 1 pair/cycle when calc readies are held high.
- Credits: each alpha_valid&alpha_ready decrements inflight and increments blocks_done. A start and an alpha return in the same cycle leave inflight unchanged.
- Errors: an alpha return while inflight=0 is ignored (inflight saturates at 0) but still counts in blocks_done.
- enable low during S_SAMPLES has no effect until the block completes. The block then waits in S_MEAN.
- Upstream readies are never asserted in the wrong state, so no x data is ever consumed in S_MEAN.

Test Plan:
- BLOCK_SIZE_LOG=2; means 640/384; x=512..515; xhat=256,258,260,262; calc readies high -> calc_xmean 640 and calc_xhatmean 384 at cycle 1; x pairs at cycles 2..5; inflight=1; state back to S_MEAN.
- MAX_INFLIGHT=2; alpha_ready held 0; 3 blocks offered -> exactly 8 sample pairs pass and the third mean is held. One alpha handshake -> third block starts the next cycle, inflight stays 2.
- calc_xhat_ready toggled 1/0 while calc_x_ready=1 -> x never advances more than 1 ahead. Upstream ready stalls until calc_xhat drains. Data order is intact (512,513,...).
- xhat_valid low for 3 cycles with x_valid high -> x_ready stays 0 and no calc_x_valid is issued.
- Alpha handshake coincident with a mean load at inflight=1 -> inflight remains 1, blocks_done increments.
- Assert rst=0 asynchronously mid-block (counter=2) -> all valids 0 immediately. After release, the next accepted word is a mean and the counter restarts at 0.
